// File: rtl/tile_ram_arbiter.sv
// Tile-map RAM arbiter: shares one sync-read RAM port between the video
// scanner and a CPU req/ack port. Video slots always win; CPU stalls at most one cycle.
module tile_ram_arbiter #(
  parameter int H_DISPLAY = 256,
  parameter int V_DISPLAY = 240,
  parameter int H_PRE     = 302,
  parameter int VID_BASE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic [7:0] vid_data,
  output logic       vid_valid,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata
);

  localparam logic [9:0] HVIS  = 10'(H_DISPLAY - 8);
  localparam logic [9:0] VVIS  = 10'(V_DISPLAY);
  localparam logic [8:0] HPRE  = 9'(H_PRE);
  localparam logic [9:0] VBASE = 10'(VID_BASE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_DATA,
    S_ACK
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] ram_addr_q, ram_addr_d;
  logic       ram_we_q, ram_we_d;
  logic [7:0] ram_wdata_q, ram_wdata_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] vid_data_q, vid_data_d;
  logic       vid_rd_q, vid_cap_q, vid_valid_q;

  logic [8:0] h_nxt;
  logic [9:0] v_nxt;
  logic       pre_hit;
  logic       slot_n;
  logic [4:0] col_nxt;
  logic [9:0] vid_addr;

  // Port registers are loaded one cycle ahead, so decode the slot for hpos+1.
  always_comb begin
    h_nxt    = hpos + 9'd1;
    v_nxt    = {1'b0, vpos} + 10'd1;
    pre_hit  = (h_nxt == HPRE) && (v_nxt < VVIS);
    slot_n   = ({1'b0, vpos} < VVIS)
             && (h_nxt[2:0] == 3'd6)
             && (({1'b0, h_nxt} < HVIS) || pre_hit);
    col_nxt  = h_nxt[7:3] + 5'd1;
    vid_addr = VBASE + (pre_hit ? {v_nxt[7:3], 5'd0}
                                : {vpos[7:3], col_nxt});
  end

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_cap_q ? ram_rdata : vid_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req && !slot_n) begin
          state_d     = S_GRANT;
          ram_addr_d  = cpu_addr;
          ram_we_d    = cpu_we;
          ram_wdata_d = cpu_wdata;
        end
      end
      S_GRANT: state_d = cpu_we ? S_ACK : S_DATA;
      S_DATA: begin
        cpu_rdata_d = ram_rdata;
        state_d     = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (slot_n) begin
      ram_addr_d = vid_addr;
      ram_we_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
      vid_rd_q    <= 1'b0;
      vid_cap_q   <= 1'b0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
      vid_rd_q    <= slot_n;
      vid_cap_q   <= vid_rd_q;
      vid_valid_q <= vid_cap_q;
    end
  end

  assign cpu_ack   = (state_q == S_ACK);
  assign cpu_rdata = cpu_rdata_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: sync-read RAM model, directed scan/CPU stimulus,
// scoreboard queues popped by monitors on vid_valid and cpu_ack.
module tb_tile_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       cpu_req, cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [7:0] vid_data;
  logic       vid_valid;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  always #5 clk = ~clk;

  tile_ram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .hpos      (hpos),
    .vpos      (vpos),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [7:0] mem    [1024];
  logic [7:0] shadow [1024];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] d;
  } vexp_t;

  typedef struct {
    logic       we;
    logic [7:0] rd;
  } cexp_t;

  vexp_t vq[$];
  cexp_t cq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic is_slot(input logic [8:0] h, input logic [8:0] v);
    int hi = int'(h);
    int vi = int'(v);
    if (vi >= 240) return 1'b0;
    if (hi % 8 != 6) return 1'b0;
    if (hi < 248) return 1'b1;
    return (hi == 302) && (vi + 1 < 240);
  endfunction

  function automatic logic [9:0] slot_addr(input logic [8:0] h,
                                           input logic [8:0] v);
    int hi = int'(h);
    int vi = int'(v);
    if (hi == 302) return 10'(((vi + 1) / 8) * 32);
    return 10'((vi / 8) * 32 + ((hi / 8 + 1) % 32));
  endfunction

  // video monitor: expected tile byte due two cycles after each slot
  always @(negedge clk) begin
    if (reset) begin
      while (vq.size() > 0 && vq[0].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL vid_missing: got none, expected %0h at cyc %0d",
                 vq[0].d, vq[0].due);
        void'(vq.pop_front());
      end
      if (vid_valid) begin
        if (vq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL vid_spurious: got %0h at hpos %0d, expected none",
                   vid_data, hpos);
        end else begin
          vexp_t it;
          it = vq.pop_front();
          chk("vid_due", cyc, it.due);
          chk("vid_data", vid_data, it.d);
        end
      end
      if (is_slot(hpos, vpos)) begin
        logic [9:0] ea;
        ea = slot_addr(hpos, vpos);
        chk("vid_addr", ram_addr, ea);
        chk("vid_we", ram_we, 0);
        vq.push_back('{cyc + 2, shadow[ea]});
      end
    end
  end

  // cpu monitor
  always @(negedge clk) begin
    if (reset && cpu_ack) begin
      if (cq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL cpu_ack_spurious: got ack at hpos %0d, expected none",
                 hpos);
      end else begin
        cexp_t c;
        c = cq.pop_front();
        if (!c.we) chk("cpu_rdata", cpu_rdata, c.rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (hpos == 9'd340) begin
      hpos = 9'd0;
      vpos = (vpos == 9'd261) ? 9'd0 : vpos + 9'd1;
    end else begin
      hpos = hpos + 9'd1;
    end
  endtask

  task automatic tick_to(input int h);
    int n = 0;
    do begin
      tick();
      n++;
    end while (int'(hpos) != h && n < 700);
    if (int'(hpos) != h) begin
      tests++;
      fails++;
      $display("FAIL tick_to: got hpos %0d, expected %0d", hpos, h);
    end
  endtask

  task automatic goto(input logic [8:0] h, input logic [8:0] v);
    while (hpos[2:0] == 3'd5) tick();
    @(posedge clk);
    #1;
    hpos = h;
    vpos = v;
  endtask

  task automatic cpu_op(input logic we, input logic [9:0] a,
                        input logic [7:0] wd, input logic [7:0] erd,
                        output int gnt_h, output int ack_h);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    cq.push_back('{we, erd});
    if (we) shadow[a] = wd;
    gnt_h = -1;
    ack_h = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (gnt_h < 0 && ram_addr == a && ram_we == we
          && (!we || ram_wdata == wd)) gnt_h = int'(hpos);
      if (cpu_ack) begin
        ack_h = int'(hpos);
        break;
      end
    end
    cpu_req = 1'b0;
    if (ack_h < 0) begin
      tests++;
      fails++;
      $display("FAIL cpu_timeout: got no ack, expected ack for addr %0h", a);
    end
  endtask

  initial begin
    int g, a;
    logic [9:0] held;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    mem[5]    = 8'hA5;
    shadow[5] = 8'hA5;
    reset     = 1'b1;
    hpos      = 9'd0;
    vpos      = 9'd0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // first cell of line 0
    tick_to(8);
    @(negedge clk);
    chk("first_vid_valid", vid_valid, 1);
    chk("first_vid_data", vid_data, 8'h5B);

    // RAM[5] read at slot 38
    tick_to(38);
    @(negedge clk);
    chk("slot38_addr", ram_addr, 10'd5);
    tick_to(40);
    @(negedge clk);
    chk("cell40_valid", vid_valid, 1);
    chk("cell40_data", vid_data, 8'hA5);

    // write then read back 0x3FF
    tick_to(0);
    cpu_op(1'b1, 10'h3FF, 8'h3C, 8'h00, g, a);
    chk("wr_grant_h", g, 1);
    chk("wr_ack_h", a, 2);
    tick();
    cpu_op(1'b0, 10'h3FF, 8'h00, 8'h3C, g, a);
    chk("rd_back", cpu_rdata, 8'h3C);

    // read requested in a video slot cycle
    tick_to(6);
    cpu_op(1'b0, 10'h3FF, 8'h00, 8'h3C, g, a);
    chk("stall_grant_h", g, 7);
    chk("stall_ack_h", a, 9);

    // next-line prefetch
    goto(9'd296, 9'd7);
    tick_to(302);
    @(negedge clk);
    chk("prefetch_addr", ram_addr, 10'd32);
    chk("prefetch_we", ram_we, 0);

    // no prefetch on the last visible line
    goto(9'd296, 9'd239);
    tick_to(301);
    @(negedge clk);
    held = ram_addr;
    tick_to(302);
    @(negedge clk);
    chk("noprefetch_addr", ram_addr, held);
    chk("noprefetch_we", ram_we, 0);
    tick_to(304);
    @(negedge clk);
    chk("noprefetch_valid", vid_valid, 0);

    // reset during a read's DATA cycle
    goto(9'd0, 9'd10);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 10'd5;
    tick();
    tick();
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    @(negedge clk);
    chk("rstmid_ack", cpu_ack, 0);
    chk("rstmid_we", ram_we, 0);
    tick();
    reset = 1'b1;
    cq.push_back('{1'b0, 8'hA5});
    @(negedge clk);
    chk("rel_ack", cpu_ack, 0);
    a = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (cpu_ack) begin
        a = int'(hpos);
        break;
      end
    end
    cpu_req = 1'b0;
    chk("rel_ack_h", a, 7);

    repeat (10) tick();
    chk("vid_q_empty", vq.size(), 0);
    chk("cpu_q_empty", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
